// File: rtl/bfly_eject_port.sv
// Ejection port of the 64-port butterfly: store-and-forward packet reassembly with whole-packet drop.
// Optional destination check enabled by defining BFLY_EJECT_DEST_CHK_EN.
module bfly_eject_port #(
    parameter int CHANNEL_WIDTH = 18,
    parameter int DEPTH         = 16,
    parameter int PORT_ID       = 0,
    parameter int CNT_WIDTH     = 16,
    localparam int DW           = CHANNEL_WIDTH - 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNEL_WIDTH-1:0] in_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [DW-1:0]        out_data,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 err_orphan,
    output logic                 err_abort,
    output logic                 err_misroute
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, base;
    logic [DW+1:0]   mem [DEPTH];
    logic [DW+1:0]   entry;

    logic            f_valid, f_head, f_tail, dest_bad;
    logic [DW-1:0]   f_data;
    logic            wr_en, wr_sop, do_commit, do_head;
    logic            orphan, abort, misroute;
    logic [1:0]      drop_inc;
    logic [CNT_WIDTH:0] drop_sum;

    assign f_valid = in_ch[CHANNEL_WIDTH-1];
    assign f_head  = in_ch[CHANNEL_WIDTH-2];
    assign f_tail  = in_ch[CHANNEL_WIDTH-3];
    assign f_data  = in_ch[DW-1:0];

`ifdef BFLY_EJECT_DEST_CHK_EN
    assign dest_bad = (f_data[DW-1 -: 6] != 6'(PORT_ID));
`else
    assign dest_bad = 1'b0;
`endif

    assign entry     = mem[rd_ptr[AW-1:0]];
    assign out_valid = (rd_ptr != commit_ptr);
    assign out_sop   = out_valid & entry[DW+1];
    assign out_eop   = out_valid & entry[DW];
    assign out_data  = out_valid ? entry[DW-1:0] : '0;

    // base is the write pointer after any rollback this cycle; fullness is judged from it
    always_comb begin
        base      = wr_ptr;
        wr_en     = 1'b0;
        wr_sop    = 1'b0;
        do_commit = 1'b0;
        do_head   = 1'b0;
        orphan    = 1'b0;
        abort     = 1'b0;
        misroute  = 1'b0;
        drop_inc  = 2'd0;
        state_n   = state;
        if (f_valid) begin
            case (state)
                IDLE: begin
                    if (f_head) do_head = 1'b1;
                    else        orphan  = 1'b1;
                end
                RECV: begin
                    if (f_head) begin
                        base     = commit_ptr;
                        abort    = 1'b1;
                        drop_inc = 2'd1;
                        do_head  = 1'b1;
                    end else if (wr_ptr - rd_ptr == PW'(DEPTH)) begin
                        base     = commit_ptr;
                        drop_inc = 2'd1;
                        state_n  = f_tail ? IDLE : DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (f_tail) begin
                            do_commit = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (f_head)      do_head = 1'b1;
                    else if (f_tail) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        if (do_head) begin
            if (dest_bad) begin
                misroute = 1'b1;
                drop_inc = drop_inc + 2'd1;
                state_n  = f_tail ? IDLE : DROP;
            end else if (base - rd_ptr == PW'(DEPTH)) begin
                drop_inc = drop_inc + 2'd1;
                state_n  = f_tail ? IDLE : DROP;
            end else begin
                wr_en     = 1'b1;
                wr_sop    = 1'b1;
                do_commit = f_tail;
                state_n   = f_tail ? IDLE : RECV;
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(drop_inc);

    always_ff @(posedge clk) begin
        if (wr_en) mem[base[AW-1:0]] <= {wr_sop, f_tail, f_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            rd_ptr       <= '0;
            pkt_cnt      <= '0;
            drop_cnt     <= '0;
            err_orphan   <= 1'b0;
            err_abort    <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_en ? base + PW'(1) : base;
            err_orphan   <= orphan;
            err_abort    <= abort;
            err_misroute <= misroute;
            if (do_commit) begin
                commit_ptr <= base + PW'(1);
                if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (out_valid && out_ready) rd_ptr <= rd_ptr + PW'(1);
            drop_cnt <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end
endmodule
